// File: rtl/serv_mtimer_pkg.sv
// Shared constants for the machine timer: register word offsets, mtimecmp reset
// value and the byte-lane write merge used by every writable register.
package serv_mtimer_pkg;

  localparam logic [1:0]  MTIME_LO    = 2'd0;
  localparam logic [1:0]  MTIME_HI    = 2'd1;
  localparam logic [1:0]  MTIMECMP_LO = 2'd2;
  localparam logic [1:0]  MTIMECMP_HI = 2'd3;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/serv_mtimer_prescaler.sv
// Free-running divider producing a one-cycle tick every PRESCALE clocks.
// PRESCALE=1 degenerates to a tick on every cycle.
module serv_mtimer_prescaler #(
  parameter int PRESCALE = 16,
  parameter int PRE_W    = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + PRE_W'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/serv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a 32-bit Wishbone slave port.
// o_mtip is a registered level of (mtime >= mtimecmp) feeding serv_csr.
module serv_mtimer
  import serv_mtimer_pkg::*;
#(
  parameter int PRESCALE = 16,
  parameter int PRE_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  logic        tick;
  logic        req, wr, rd;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdt_q, rdt_d;
  logic        ack_q, ack_d;
  logic        mtip_q, mtip_d;

  serv_mtimer_prescaler #(
    .PRESCALE (PRESCALE),
    .PRE_W    (PRE_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  // Masking with the ack flop keeps a held strobe from being served twice in a row.
  assign req = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr  = req & i_wb_we;
  assign rd  = req & ~i_wb_we;

  // A write to either mtime half takes the whole cycle: the tick is dropped, no carry.
  always_comb begin
    mtime_d = mtime_q;
    if (wr && i_wb_adr == MTIME_LO)
      mtime_d = {mtime_q[63:32], lane_merge(mtime_q[31:0], i_wb_dat, i_wb_sel)};
    else if (wr && i_wb_adr == MTIME_HI)
      mtime_d = {lane_merge(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]};
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr && i_wb_adr == MTIMECMP_LO)
      mtimecmp_d = {mtimecmp_q[63:32], lane_merge(mtimecmp_q[31:0], i_wb_dat, i_wb_sel)};
    else if (wr && i_wb_adr == MTIMECMP_HI)
      mtimecmp_d = {lane_merge(mtimecmp_q[63:32], i_wb_dat, i_wb_sel), mtimecmp_q[31:0]};
  end

  always_comb begin
    rdt_d = rdt_q;
    if (rd) begin
      case (i_wb_adr)
        MTIME_LO:    rdt_d = mtime_q[31:0];
        MTIME_HI:    rdt_d = mtime_q[63:32];
        MTIMECMP_LO: rdt_d = mtimecmp_q[31:0];
        default:     rdt_d = mtimecmp_q[63:32];
      endcase
    end
  end

  assign ack_d  = req;
  assign mtip_d = (mtime_q >= mtimecmp_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      rdt_q      <= '0;
      ack_q      <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdt_q      <= rdt_d;
      ack_q      <= ack_d;
      mtip_q     <= mtip_d;
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_mtip   = mtip_q;

endmodule

// File: tb/tb_serv_mtimer.sv
// Directed bench for serv_mtimer with PRESCALE=4; ticks land on edges whose
// post-reset edge number is a multiple of 4.
module tb_serv_mtimer;

  localparam logic [1:0] A_MTIME_LO = 2'd0;
  localparam logic [1:0] A_MTIME_HI = 2'd1;
  localparam logic [1:0] A_CMP_LO   = 2'd2;
  localparam logic [1:0] A_CMP_HI   = 2'd3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        mtip;

  int checks = 0;
  int passed = 0;
  int cyc_cnt;

  serv_mtimer #(
    .PRESCALE (4),
    .PRE_W    (2)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_adr (wb_adr),
    .i_wb_dat (wb_dat),
    .i_wb_sel (wb_sel),
    .i_wb_we  (wb_we),
    .i_wb_cyc (wb_cyc),
    .i_wb_stb (wb_stb),
    .o_wb_rdt (wb_rdt),
    .o_wb_ack (wb_ack),
    .o_mtip   (mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges since reset release; edge k carries a tick when k%4==0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt <= 0;
    else        cyc_cnt <= cyc_cnt + 1;
  end

  // One single-beat access: request edge, then one idle edge. Samples taken #1 after each edge.
  task automatic apply_stimulus(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                                input logic [3:0] sel, output logic [31:0] rdt,
                                output logic ack1, output logic ack2,
                                output logic mtip1, output logic mtip2);
    wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    ack1 = wb_ack; rdt = wb_rdt; mtip1 = mtip;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    ack2 = wb_ack; mtip2 = mtip;
  endtask

  // Advance until the next request edge number is congruent to m modulo 4.
  task automatic wait_phase(input int m);
    for (int i = 0; i < 8; i++) begin
      if (cyc_cnt % 4 != (m + 3) % 4) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] r; logic a1, a2, m1, m2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    checks++; if ({wb_ack, mtip, wb_rdt} !== 34'd0) $display("[TB] FAIL reset_outputs ack=%b mtip=%b rdt=%h expected all zero", wb_ack, mtip, wb_rdt); else passed++;
    @(posedge clk); #1;
    wb_adr = A_MTIME_LO; wb_we = 1'b0; wb_sel = 4'hF; wb_dat = '0;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) $display("[TB] FAIL reset_mid_read_ack got %b expected 0", wb_ack); else passed++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_ack !== 1'b0) $display("[TB] FAIL reset_release_ack got %b expected 0", wb_ack); else passed++;
    apply_stimulus(A_MTIME_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd0) $display("[TB] FAIL reset_mtime_lo got %h expected 00000000", r); else passed++;
    apply_stimulus(A_CMP_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'hFFFF_FFFF) $display("[TB] FAIL reset_cmp_lo got %h expected ffffffff", r); else passed++;
    apply_stimulus(A_CMP_HI, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'hFFFF_FFFF) $display("[TB] FAIL reset_cmp_hi got %h expected ffffffff", r); else passed++;
    apply_stimulus(A_MTIME_HI, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd0) $display("[TB] FAIL reset_mtime_hi got %h expected 00000000", r); else passed++;
    checks++; if (mtip !== 1'b0) $display("[TB] FAIL reset_mtip got %b expected 0", mtip); else passed++;
  endtask

  task automatic test_prescale;
    logic [31:0] r; logic a1, a2, m1, m2;
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    apply_stimulus(A_MTIME_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd10) $display("[TB] FAIL prescale_mtime_lo got %0d expected 10", r); else passed++;
    checks++; if ({a1, a2} !== 2'b10) $display("[TB] FAIL ack_width got %b expected 10", {a1, a2}); else passed++;
  endtask

  task automatic test_carry;
    logic [31:0] r; logic a1, a2, m1, m2;
    wait_phase(1);
    apply_stimulus(A_MTIME_LO, 1'b1, 32'hFFFF_FFFF, 4'hF, r, a1, a2, m1, m2);
    apply_stimulus(A_MTIME_HI, 1'b1, 32'h0, 4'hF, r, a1, a2, m1, m2);
    apply_stimulus(A_MTIME_HI, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd1) $display("[TB] FAIL carry_hi got %h expected 00000001", r); else passed++;
    apply_stimulus(A_MTIME_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd0) $display("[TB] FAIL carry_lo got %h expected 00000000", r); else passed++;
    wait_phase(1);
    apply_stimulus(A_MTIME_LO, 1'b1, 32'hFFFF_FFFF, 4'hF, r, a1, a2, m1, m2);
    apply_stimulus(A_MTIME_HI, 1'b1, 32'hFFFF_FFFF, 4'hF, r, a1, a2, m1, m2);
    apply_stimulus(A_MTIME_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd0) $display("[TB] FAIL wrap_lo got %h expected 00000000", r); else passed++;
    apply_stimulus(A_MTIME_HI, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd0) $display("[TB] FAIL wrap_hi got %h expected 00000000", r); else passed++;
  endtask

  task automatic test_mtip;
    logic [31:0] r; logic a1, a2, m1, m2;
    int e;
    apply_stimulus(A_CMP_HI, 1'b1, 32'd0, 4'hF, r, a1, a2, m1, m2);
    apply_stimulus(A_CMP_LO, 1'b1, 32'd100, 4'hF, r, a1, a2, m1, m2);
    checks++; if (mtip !== 1'b0) $display("[TB] FAIL mtip_before got %b expected 0", mtip); else passed++;
    apply_stimulus(A_MTIME_HI, 1'b1, 32'd0, 4'hF, r, a1, a2, m1, m2);
    wait_phase(0);
    apply_stimulus(A_MTIME_LO, 1'b1, 32'd0, 4'hF, r, a1, a2, m1, m2);
    e = cyc_cnt - 1;
    for (int i = 0; i < 500; i++) begin
      if (cyc_cnt != e + 400) begin
        @(posedge clk); #1;
      end
    end
    checks++; if (cyc_cnt != e + 400) $display("[TB] FAIL mtip_wait_timeout cycle %0d expected %0d", cyc_cnt, e + 400); else passed++;
    checks++; if (mtip !== 1'b0) $display("[TB] FAIL mtip_early got %b expected 0", mtip); else passed++;
    @(posedge clk); #1;
    checks++; if (mtip !== 1'b1) $display("[TB] FAIL mtip_rise got %b expected 1", mtip); else passed++;
    apply_stimulus(A_CMP_LO, 1'b1, 32'd1000, 4'hF, r, a1, a2, m1, m2);
    checks++; if ({m1, m2} !== 2'b10) $display("[TB] FAIL mtip_fall got %b expected 10", {m1, m2}); else passed++;
  endtask

  task automatic test_lane_write;
    logic [31:0] r; logic a1, a2, m1, m2;
    wait_phase(0);
    apply_stimulus(A_MTIME_LO, 1'b1, 32'h1122_3344, 4'hF, r, a1, a2, m1, m2);
    wait_phase(0);
    apply_stimulus(A_MTIME_LO, 1'b1, 32'h0000_AB00, 4'b0010, r, a1, a2, m1, m2);
    apply_stimulus(A_MTIME_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'h1122_AB44) $display("[TB] FAIL lane_write_lo got %h expected 1122ab44", r); else passed++;
    apply_stimulus(A_MTIME_HI, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'd0) $display("[TB] FAIL lane_write_hi got %h expected 00000000", r); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; logic a1, a2, m1, m2;
    logic [5:0] acks;
    logic [31:0] rd_seen;
    wait_phase(3);
    wb_adr = A_MTIME_LO; wb_we = 1'b1; wb_dat = 32'h0000_0500; wb_sel = 4'hF;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks[i] = wb_ack;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    checks++; if (acks !== 6'b010101) $display("[TB] FAIL b2b_write_acks got %b expected 010101", acks); else passed++;
    apply_stimulus(A_MTIME_LO, 1'b0, '0, 4'hF, r, a1, a2, m1, m2);
    checks++; if (r !== 32'h0000_0501) $display("[TB] FAIL b2b_write_value got %h expected 00000501", r); else passed++;
    wb_adr = A_CMP_LO; wb_we = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    rd_seen = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks[i] = wb_ack;
      if (wb_ack) rd_seen = wb_rdt;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    checks++; if (acks !== 6'b010101) $display("[TB] FAIL b2b_read_acks got %b expected 010101", acks); else passed++;
    checks++; if (rd_seen !== 32'd1000) $display("[TB] FAIL b2b_read_value got %0d expected 1000", rd_seen); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    wb_adr = '0;
    wb_dat = '0;
    wb_sel = '0;
    wb_we  = 1'b0;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    test_reset;
    test_prescale;
    test_carry;
    test_mtip;
    test_lane_write;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
